slave_port: RTL and testbench
=============================

# slave_port

Responder end of the serial system bus. It deserialises the LSB-first address and write-data stream that a master port drives, performs one parallel access on the attached slave memory device, and for reads serialises the returned word back to the master with `svalid` qualification. It sits between the bus interconnect (after address decode) and one slave device.

## Interface
- `ADDR_WIDTH`, 12: slave-local memory address width (bus address minus the 4-bit slave select field).
- `DATA_WIDTH`, 8: data word width.

- `clk`  in  1  bus clock; all logic rising-edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `swdata`  in  1  serial address/write data from master (`mwdata`).
- `smode`  in  1  transaction mode from master: 0 read, 1 write; stable for the whole transaction.
- `mvalid`  in  1  `swdata` bit valid; already qualified by the slave decoder.
- `srdata`  out  1  serial read data to master (`mrdata`).
- `svalid`  out  1  `srdata` bit valid.
- `sbusy`  out  1  high whenever state ≠ IDLE.
- `smemaddr`  out  ADDR_WIDTH  memory address, held from end of address phase until next transaction.
- `smemwdata`  out  DATA_WIDTH  memory write data.
- `smemwen`  out  1  single-cycle write strobe.
- `smemren`  out  1  read request, level, held until `smemrvalid`.
- `smemrdata`  in  DATA_WIDTH  memory read data, sampled when `smemrvalid`=1.
- `smemrvalid`  in  1  read data valid; any latency ≥0 cycles after `smemren` rises.

## Operation
- States: IDLE, ADDR, WDATA, WRITE, READ, RDATA.
- IDLE: on `mvalid`=1 capture `swdata` into addr bit 0, counter←1, go ADDR.
- ADDR: each cycle with `mvalid`=1 capture addr[counter], counter+1. On capture of bit ADDR_WIDTH-1: counter←0; `smode`=1 → WDATA, else → READ. `mvalid`=0 in ADDR → abort to IDLE, no memory access.
- WDATA: each `mvalid`=1 cycle capture wdata[counter]; on bit DATA_WIDTH-1 → WRITE. `mvalid`=0 → abort to IDLE.
- WRITE: `smemwen`=1 for exactly this cycle with `smemaddr`/`smemwdata` stable → IDLE.
- READ: `smemren`=1 every cycle in READ. When `smemrvalid`=1 latch `smemrdata` into read buffer, counter←0 → RDATA. `mvalid` ignored.
- RDATA: `svalid`=1, `srdata`=rbuf[counter]; counter+1 each cycle; after bit DATA_WIDTH-1 → IDLE. Exactly DATA_WIDTH consecutive `svalid` cycles, LSB first, no gaps.
- `mvalid` ignored in WRITE, READ, RDATA; any stray bits are dropped, not queued.
- Counter width: clog2(max(ADDR_WIDTH, DATA_WIDTH))+1; never wraps within a phase.
- `svalid`, `srdata`, `smemwen`, `smemren`, `sbusy` decoded only from state/counter/buffer flops (no input-to-output combinational path).

## Timing
- Reset (async assert, sync-released use): state IDLE; all outputs 0; address, write, read buffers 0; counter 0.
- Reset mid-transaction: immediate return to IDLE, no `smemwen`, `smemren` drops, `svalid` drops; partial data discarded.
- Write: master's 20 consecutive `mvalid` cycles (default params) → `smemwen` in cycle 21 → IDLE cycle 22; new transaction accepted from cycle 22.
- Read: `smemren` rises the cycle after last address bit; `smemrvalid` same cycle → `svalid` first bit next cycle. Read latency = memory latency + 1 cycle to first bit.
- `smemrvalid` outside READ: ignored.
- Back-to-back: `mvalid`=1 in the cycle state returns IDLE is captured as bit 0 of the next transaction.

## Structure
- Shared bus package: SLAVE_ADDR_WIDTH=4 constant, state encoding localparams, read/write mode constants (shared with master port).
- Single module; no sub-module needed (shift capture and serialiser are a few lines each).

## Test plan
- Write addr 0x5A3, data 0xC6 (20 mvalid cycles, LSB first) → one `smemwen` pulse with `smemaddr`=0x5A3, `smemwdata`=0xC6; `svalid` never asserted.
- Read addr 0x0F0, memory returns 0x3C 3 cycles after `smemren` → `smemren` high 4 cycles, then 8 `svalid` cycles with `srdata` 0,0,1,1,1,1,0,0.
- Read with `smemrvalid` in same cycle as `smemren` rises, data 0xA5 → `svalid` begins next cycle, bits 1,0,1,0,0,1,0,1.
- `mvalid` drops after 5 address bits → IDLE, no `smemwen`/`smemren`; following write to 0x001 data 0xFF completes correctly.
- `rstn` asserted during 4th RDATA bit → `svalid`, `srdata`, `sbusy` go 0 immediately; after release, read of 0x7FF returns memory data correctly.
- Write 0x123/0x55 immediately followed by read 0x123 (memory models write) → read serialises 0x55.

Source files
------------

// File: rtl/slave_port_pkg.sv
// -----------------------------------------------------------------------------
// slave_port_pkg
// Shared serial-bus definitions used by the master and slave ports:
//   - SLAVE_ADDR_WIDTH : width of the slave-select field at the top of a bus address
//   - MODE_READ/WRITE  : values carried on the smode/mmode line
//   - ST_*             : slave port FSM state encoding
//   - sp_cnt_width()   : bit-counter width that covers both address and data phases
// -----------------------------------------------------------------------------
package slave_port_pkg;

  localparam int SLAVE_ADDR_WIDTH = 4;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef logic [2:0] sp_state_t;

  localparam sp_state_t ST_IDLE  = 3'd0;
  localparam sp_state_t ST_ADDR  = 3'd1;
  localparam sp_state_t ST_WDATA = 3'd2;
  localparam sp_state_t ST_WRITE = 3'd3;
  localparam sp_state_t ST_READ  = 3'd4;
  localparam sp_state_t ST_RDATA = 3'd5;

  // One spare bit so the counter never wraps inside a phase.
  function automatic int sp_cnt_width(input int a_w, input int d_w);
    return $clog2((a_w > d_w) ? a_w : d_w) + 1;
  endfunction

endpackage

// File: rtl/slave_port.sv
// -----------------------------------------------------------------------------
// slave_port
// Responder end of the serial system bus. Deserialises an LSB-first address
// (and, for writes, data) stream, performs one parallel access on the attached
// memory, and for reads serialises the returned word back with svalid.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   swdata, smode      serial address/write data and mode (0 read, 1 write)
//   mvalid             swdata bit valid (already slave-decoded)
//   srdata, svalid     serial read data and its qualifier
//   sbusy              high whenever the FSM is not idle
//   smemaddr/smemwdata memory address and write data
//   smemwen            one-cycle write strobe
//   smemren            read request level, held until smemrvalid
//   smemrdata/valid    memory read return
//   o_dbg_state        current FSM state (ST_* encoding)
//
// Handshake: a bit is transferred on swdata in every cycle where mvalid=1 in
// the ADDR/WDATA phases (mvalid=0 there aborts); memory read data is taken in
// the first READ cycle with smemrvalid=1; read data leaves as DATA_WIDTH
// back-to-back svalid cycles with no backpressure.
// -----------------------------------------------------------------------------
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sbusy,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  output logic                  smemwen,
  output logic                  smemren,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  input  logic                  smemrvalid,
  output logic [2:0]            o_dbg_state
);

  localparam int CW = sp_cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  sp_state_t             r_state;
  logic [CW-1:0]         r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rbuf;

  // Capture shifts in at the MSB and moves right, so after a full LSB-first
  // phase the first bit received sits in bit 0. The read buffer shifts right
  // so bit 0 is always the bit on the wire.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rbuf  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mvalid) begin
            r_addr  <= {swdata, r_addr[ADDR_WIDTH-1:1]};
            r_cnt   <= CW'(1);
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (mvalid) begin
            r_addr <= {swdata, r_addr[ADDR_WIDTH-1:1]};
            if (r_cnt == ADDR_LAST) begin
              r_cnt   <= '0;
              r_state <= (smode == MODE_WRITE) ? ST_WDATA : ST_READ;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_WDATA: begin
          if (mvalid) begin
            r_wdata <= {swdata, r_wdata[DATA_WIDTH-1:1]};
            if (r_cnt == DATA_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_WRITE;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          r_state <= ST_IDLE;
        end
        ST_READ: begin
          if (smemrvalid) begin
            r_rbuf  <= smemrdata;
            r_cnt   <= '0;
            r_state <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          r_rbuf <= {1'b0, r_rbuf[DATA_WIDTH-1:1]};
          if (r_cnt == DATA_LAST) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs decode flops only; no input reaches an output combinationally.
  assign svalid      = (r_state == ST_RDATA);
  assign srdata      = (r_state == ST_RDATA) & r_rbuf[0];
  assign smemwen     = (r_state == ST_WRITE);
  assign smemren     = (r_state == ST_READ);
  assign sbusy       = (r_state != ST_IDLE);
  assign smemaddr    = r_addr;
  assign smemwdata   = r_wdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_slave_port.sv
module tb_slave_port;

  logic        clk;
  logic        rstn;
  logic        swdata;
  logic        smode;
  logic        mvalid;
  logic        srdata;
  logic        svalid;
  logic        sbusy;
  logic [11:0] smemaddr;
  logic [7:0]  smemwdata;
  logic        smemwen;
  logic        smemren;
  logic [7:0]  smemrdata = 8'h00;
  logic        smemrvalid = 1'b0;
  logic [2:0]  o_dbg_state;

  int total = 0;
  int bad   = 0;

  // scoreboard queues
  logic [0:0]  exp_bit_q[$];
  logic [19:0] exp_wr_q[$];

  // monitor counters
  int n_wen = 0;
  int n_ren = 0;
  int n_sv  = 0;
  int sv_run = 0;

  // memory model
  logic [7:0] mem [4096];
  int mem_lat = 0;
  int lat_cnt = 0;

  slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .swdata      (swdata),
    .smode       (smode),
    .mvalid      (mvalid),
    .srdata      (srdata),
    .svalid      (svalid),
    .sbusy       (sbusy),
    .smemaddr    (smemaddr),
    .smemwdata   (smemwdata),
    .smemwen     (smemwen),
    .smemren     (smemren),
    .smemrdata   (smemrdata),
    .smemrvalid  (smemrvalid),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory responder (drives on negedge) ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      smemrvalid = 1'b0;
      smemrdata  = 8'h00;
      lat_cnt    = 0;
    end else begin
      if (smemwen) mem[smemaddr] = smemwdata;
      if (smemren) begin
        if (lat_cnt >= mem_lat) begin
          smemrvalid = 1'b1;
          smemrdata  = mem[smemaddr];
          lat_cnt    = 0;
        end else begin
          smemrvalid = 1'b0;
          smemrdata  = $urandom_range(0, 255);
          lat_cnt++;
        end
      end else begin
        smemrvalid = 1'b0;
        lat_cnt    = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      sv_run = 0;
    end else begin
      if (smemwen) begin
        n_wen++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_addr_data", {12'd0, smemaddr, smemwdata}, {12'd0, exp_wr_q.pop_front()});
      end
      if (smemren) n_ren++;
      if (svalid) begin
        n_sv++;
        sv_run++;
        if (exp_bit_q.size() == 0) check("rd_unexpected_bit", 32'd1, 32'd0);
        else check("rd_bit", {31'd0, srdata}, {31'd0, exp_bit_q.pop_front()});
      end else if (sv_run > 0) begin
        check("rd_burst_len", sv_run, 8);
        sv_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      swdata = v[i];
      mvalid = 1'b1;
      @(negedge clk);
    end
    mvalid = 1'b0;
    swdata = 1'b0;
  endtask

  // Returns at the negedge of the WRITE cycle.
  task automatic do_write(input logic [11:0] a, input logic [7:0] d);
    smode = 1'b1;
    exp_wr_q.push_back({a, d});
    send_bits({12'd0, d, a}, 20);
    check("wr_strobe_cycle21", {31'd0, smemwen}, 32'd1);
  endtask

  // Returns at the negedge of the first READ cycle.
  task automatic do_read(input logic [11:0] a, input logic [7:0] d, input int lat);
    mem_lat = lat;
    smode   = 1'b0;
    for (int i = 0; i < 8; i++) exp_bit_q.push_back(d[i]);
    send_bits({20'd0, a}, 12);
    check("rd_ren_rise", {31'd0, smemren}, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!sbusy && exp_bit_q.size() == 0) break;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, sbusy}, 32'd0);
    check("rd_queue_drained", exp_bit_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  int b_wen, b_ren, b_sv, k;

  initial begin
    rstn   = 1'b0;
    swdata = 1'b0;
    smode  = 1'b0;
    mvalid = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h0F0] = 8'h3C;
    mem[12'h0A0] = 8'hA5;
    mem[12'h7FF] = 8'h9B;
    mem[12'h123] = 8'hEE;

    repeat (3) @(negedge clk);
    check("rst_sbusy",  {31'd0, sbusy},   32'd0);
    check("rst_svalid", {31'd0, svalid},  32'd0);
    check("rst_srdata", {31'd0, srdata},  32'd0);
    check("rst_wen",    {31'd0, smemwen}, 32'd0);
    check("rst_ren",    {31'd0, smemren}, 32'd0);
    check("rst_addr",   {20'd0, smemaddr},  32'd0);
    check("rst_wdata",  {24'd0, smemwdata}, 32'd0);
    check("rst_state",  {29'd0, o_dbg_state}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 1: write 0x5A3 <- 0xC6
    b_sv = n_sv; b_wen = n_wen;
    do_write(12'h5A3, 8'hC6);
    check("wr1_addr",  {20'd0, smemaddr},  32'h5A3);
    check("wr1_wdata", {24'd0, smemwdata}, 32'hC6);
    @(negedge clk);
    check("wr1_wen_single", {31'd0, smemwen}, 32'd0);
    check("wr1_idle_c22",   {31'd0, sbusy},   32'd0);
    check("wr1_wen_count",  n_wen - b_wen, 1);
    check("wr1_no_svalid",  n_sv - b_sv, 0);

    // 2: read 0x0F0, memory latency 3 -> 0x3C
    b_ren = n_ren; b_sv = n_sv;
    do_read(12'h0F0, 8'h3C, 3);
    wait_idle();
    check("rd2_ren_cycles", n_ren - b_ren, 4);
    check("rd2_sv_cycles",  n_sv - b_sv, 8);

    // 3: read 0x0A0, zero memory latency -> 0xA5
    do_read(12'h0A0, 8'hA5, 0);
    @(negedge clk);
    check("rd3_sv_next_cycle", {31'd0, svalid}, 32'd1);
    wait_idle();

    // 4: abort after 5 address bits, then write 0x001 <- 0xFF
    b_wen = n_wen; b_ren = n_ren;
    smode = 1'b1;
    send_bits(32'h1F, 5);
    check("abort_still_busy", {31'd0, sbusy}, 32'd1);
    @(negedge clk);
    check("abort_idle",   {31'd0, sbusy}, 32'd0);
    check("abort_no_wen", n_wen - b_wen, 0);
    check("abort_no_ren", n_ren - b_ren, 0);
    do_write(12'h001, 8'hFF);
    @(negedge clk);
    check("wr4_wen_count", n_wen - b_wen, 1);

    // 5: reset during the 4th read bit of 0x7FF, then read again
    mem_lat = 1;
    smode   = 1'b0;
    for (int i = 0; i < 8; i++) exp_bit_q.push_back(mem[12'h7FF][i]);
    send_bits(32'h7FF, 12);
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (svalid) begin
        k++;
        if (k == 4) break;
      end
    end
    check("rst5_reached_bit4", k, 4);
    check("rst5_bit4_high", {31'd0, srdata}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("rst5_svalid", {31'd0, svalid}, 32'd0);
    check("rst5_srdata", {31'd0, srdata}, 32'd0);
    check("rst5_sbusy",  {31'd0, sbusy},  32'd0);
    check("rst5_ren",    {31'd0, smemren}, 32'd0);
    exp_bit_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    b_sv = n_sv;
    do_read(12'h7FF, 8'h9B, 2);
    wait_idle();
    check("rd5_sv_cycles", n_sv - b_sv, 8);

    // 6: write 0x123 <- 0x55, back-to-back read of 0x123
    do_write(12'h123, 8'h55);
    @(negedge clk);
    b_sv = n_sv;
    do_read(12'h123, 8'h55, $urandom_range(0, 4));
    wait_idle();
    check("rd6_sv_cycles", n_sv - b_sv, 8);
    check("wr_queue_drained", exp_wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
